// File: rtl/bit_pixel_rotator_nbuf.sv
// Column-major bit-pixel writer into an N-buffer, S-section block-matching BRAM, fed by a show-ahead FIFO.
// Latency 1 clk from FIFO write to BRAM write; stalls reads (FIFO keeps filling) while the next buffer is busy.

module bit_pixel_rotator_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 512,
  parameter int AFULL = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_vld,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_rd_rdy,
  output logic [DW-1:0] o_rd_dat,
  output logic          o_empty,
  output logic          o_afull,
  output logic          o_overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic          r_afull;
  logic          r_overflow;
  logic [PW:0]   w_used;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;

  assign w_used   = r_wptr - r_rptr;
  assign w_full   = (w_used == (PW+1)'(DEPTH));
  assign o_empty  = (w_used == '0);
  assign w_rd     = i_rd_rdy && !o_empty;
  // A read in the same cycle frees the slot, so a write into a full FIFO is fine then.
  assign w_wr     = i_wr_vld && (!w_full || w_rd);
  assign o_rd_dat = r_mem[r_rptr[PW-1:0]];
  assign o_afull    = r_afull;
  assign o_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[PW-1:0]] <= i_wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_afull <= (32'(w_used) > AFULL);
      if (i_wr_vld && !w_wr) r_overflow <= 1'b1;
    end
  end
endmodule

module bit_pixel_rotator_nbuf #(
  parameter int THIRD_COLS   = 240,
  parameter int THIRD_ROWS   = 480,
  parameter int NUM_PIX      = 16,
  parameter int NUM_SECTIONS = 3,
  parameter int NUM_BUFS     = 2,
  parameter int FIFO_DEPTH   = 512,
  parameter int AFULL_LEVEL  = 32,
  parameter int TEST_MODE    = 0,
  localparam int WR_COLS = THIRD_COLS / NUM_PIX,
  localparam int ADDR_W  = $clog2(WR_COLS * THIRD_ROWS),
  localparam int SEC_W   = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1,
  localparam int BUF_W   = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  localparam int AW      = BUF_W + SEC_W + ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_PIX+7:0] bit_pix,
  input  logic               bit_pix_valid,
  output logic               fifo_almost_full,
  output logic               fifo_overflow,
  output logic [NUM_PIX-1:0] pix_out,
  output logic               pix_out_wren,
  output logic [AW-1:0]      pix_out_addr,
  input  logic [NUM_BUFS-1:0] bm_busy_mask,
  output logic [BUF_W-1:0]   cur_buf,
  output logic [3:0]         image_number,
  output logic               frame_done,
  output logic [BUF_W-1:0]   done_buf,
  output logic [7:0]         sync_err_cnt
);
  localparam int ROW_W = (THIRD_ROWS > 1) ? $clog2(THIRD_ROWS) : 1;
  localparam int COL_W = (WR_COLS > 1) ? $clog2(WR_COLS) : 1;

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t             r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [ADDR_W-1:0]  r_addr;
  logic [BUF_W-1:0]   r_cur_buf;
  logic [BUF_W-1:0]   r_done_buf;
  logic [3:0]         r_image_number;
  logic               r_frame_done;
  logic [7:0]         r_sync_err_cnt;

  logic [NUM_PIX+7:0] w_head;
  logic               w_empty;
  logic               w_wren;
  logic               w_sof;
  logic [1:0]         w_sec_raw;
  logic [SEC_W-1:0]   w_sec;
  logic               w_resync;
  logic [ROW_W-1:0]   w_row_e;
  logic [COL_W-1:0]   w_col_e;
  logic [ADDR_W-1:0]  w_addr_e;
  logic               w_row_last;
  logic               w_col_last;
  logic               w_img_end;
  logic [BUF_W-1:0]   w_nxt_buf;
  logic               w_nxt_free;
  logic [AW-1:0]      w_addr;
  logic [NUM_PIX-1:0] w_tm_pix;
  logic               w_unused;

  bit_pixel_rotator_fifo #(
    .DW    (NUM_PIX + 8),
    .DEPTH (FIFO_DEPTH),
    .AFULL (AFULL_LEVEL)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_vld   (bit_pix_valid),
    .i_wr_dat   (bit_pix),
    .i_rd_rdy   (w_wren),
    .o_rd_dat   (w_head),
    .o_empty    (w_empty),
    .o_afull    (fifo_almost_full),
    .o_overflow (fifo_overflow)
  );

  assign w_wren    = (r_state == ST_RUN) && !w_empty;
  assign w_sof     = w_head[NUM_PIX+1];
  assign w_sec_raw = w_head[NUM_PIX+3:NUM_PIX+2];
  assign w_sec     = SEC_W'(w_sec_raw);
  assign w_unused  = ^{w_head[NUM_PIX+7:NUM_PIX+4], w_head[NUM_PIX]};

  // A misplaced SOF is treated as if the write position were the section origin.
  assign w_resync   = w_sof && ((r_row != '0) || (r_col != '0));
  assign w_row_e    = w_resync ? '0 : r_row;
  assign w_col_e    = w_resync ? '0 : r_col;
  assign w_addr_e   = w_resync ? '0 : r_addr;
  assign w_row_last = (w_row_e == ROW_W'(THIRD_ROWS - 1));
  assign w_col_last = (w_col_e == COL_W'(WR_COLS - 1));
  assign w_img_end  = w_wren && w_row_last && w_col_last &&
                      (w_sec_raw == 2'(NUM_SECTIONS - 1));

  assign w_nxt_buf  = (r_cur_buf == BUF_W'(NUM_BUFS - 1)) ? '0 : r_cur_buf + 1'b1;
  assign w_nxt_free = !bm_busy_mask[w_nxt_buf];

  assign w_addr = {r_cur_buf, w_sec, w_addr_e};

  generate
    if (AW >= NUM_PIX) begin : g_tm_trunc
      assign w_tm_pix = w_addr[NUM_PIX-1:0];
    end else begin : g_tm_ext
      assign w_tm_pix = {{(NUM_PIX-AW){1'b0}}, w_addr};
    end
  endgenerate

  assign pix_out_wren = w_wren;
  assign pix_out_addr = w_wren ? w_addr : '0;
  assign pix_out      = !w_wren ? '0 :
                        (TEST_MODE != 0) ? w_tm_pix : w_head[NUM_PIX-1:0];

  assign cur_buf      = r_cur_buf;
  assign done_buf     = r_done_buf;
  assign image_number = r_image_number;
  assign frame_done   = r_frame_done;
  assign sync_err_cnt = r_sync_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_row          <= '0;
      r_col          <= '0;
      r_addr         <= '0;
      r_cur_buf      <= '0;
      r_done_buf     <= '0;
      r_image_number <= '0;
      r_frame_done   <= 1'b0;
      r_sync_err_cnt <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_wren) begin
        if (w_resync && (r_sync_err_cnt != 8'hFF))
          r_sync_err_cnt <= r_sync_err_cnt + 1'b1;
        // Rows advance first: consecutive words go down a column.
        if (w_row_last) begin
          r_row <= '0;
          if (w_col_last) begin
            r_col  <= '0;
            r_addr <= '0;
          end else begin
            r_col  <= w_col_e + 1'b1;
            r_addr <= ADDR_W'(w_col_e) + 1'b1;
          end
        end else begin
          r_row  <= w_row_e + 1'b1;
          r_addr <= w_addr_e + ADDR_W'(WR_COLS);
        end
        if (w_img_end) begin
          if (w_nxt_free) begin
            r_cur_buf      <= w_nxt_buf;
            r_done_buf     <= r_cur_buf;
            r_image_number <= r_image_number + 1'b1;
            r_frame_done   <= 1'b1;
          end else begin
            r_state <= ST_STALL;
          end
        end
      end else if ((r_state == ST_STALL) && w_nxt_free) begin
        r_cur_buf      <= w_nxt_buf;
        r_done_buf     <= r_cur_buf;
        r_image_number <= r_image_number + 1'b1;
        r_frame_done   <= 1'b1;
        r_state        <= ST_RUN;
      end
    end
  end
endmodule

// File: doc/bit_pixel_rotator_nbuf.md
# bit_pixel_rotator_nbuf

Parametrised successor to the single-ping-pong bit-pixel rotator. It accepts packed bit-pixel words from the DDR3 reader into an internal show-ahead FIFO. It writes them column-major into an N-buffer, S-section block-matching BRAM and advances buffers round-robin, holding off any buffer the block matchers are still reading. It also adds SOF resynchronisation, overflow detection and a frame-done strobe for the block-matching FSM.

## Interface
- THIRD_COLS, 240, columns per section; must be a multiple of NUM_PIX
- THIRD_ROWS, 480, rows per section
- NUM_PIX, 16, pixels per word
- NUM_SECTIONS, 3, sections per image (1..4)
- NUM_BUFS, 2, image buffers (2..4)
- FIFO_DEPTH, 512, input FIFO words (power of 2)
- AFULL_LEVEL, 32, almost-full threshold (used words)
- TEST_MODE, 0, 1 = write address pattern instead of pixels
- Derived values:
  - WR_COLS = THIRD_COLS/NUM_PIX
  - ADDR_W = clog2(WR_COLS*THIRD_ROWS)
  - SEC_W = max(1, clog2(NUM_SECTIONS))
  - BUF_W = max(1, clog2(NUM_BUFS))
  - AW = BUF_W+SEC_W+ADDR_W
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- bit_pix  in  NUM_PIX+8  input word:
  - [NUM_PIX-1:0] pixels
  - [NUM_PIX] eof (ignored)
  - [NUM_PIX+1] sof
  - [NUM_PIX+3:NUM_PIX+2] section index
  - upper bits ignored
- bit_pix_valid  in  1  write strobe
- fifo_almost_full  out  1  used words > AFULL_LEVEL
- fifo_overflow  out  1  sticky: a valid word arrived while FIFO full
- pix_out  out  NUM_PIX  BRAM write data
- pix_out_wren  out  1  BRAM write enable
- pix_out_addr  out  AW  {buf, section, wr_addr}
- bm_busy_mask  in  NUM_BUFS  bit b = buffer b being read by block matchers
- cur_buf  out  BUF_W  buffer being written
- image_number  out  4  completed-image counter, wraps
- frame_done  out  1  one-cycle pulse when an image completes
- done_buf  out  BUF_W  buffer just completed (valid with frame_done)
- sync_err_cnt  out  8  saturating count of SOF resyncs

## Operation
- FIFO: show-ahead, single clock. A write while full is dropped and sets fifo_overflow, which is cleared only by reset. A simultaneous read and write while full is legal and is not an overflow.
- States are ST_RUN and ST_STALL.
- pix_out_wren = (state==ST_RUN) && !fifo_empty. The FIFO read equals pix_out_wren.
- Address counters are write_row (0..THIRD_ROWS-1) and write_col (0..WR_COLS-1).
  - wr_addr = write_row*WR_COLS + write_col, maintained incrementally.
  - Row step adds WR_COLS.
  - On a row wrap, wr_addr = write_col+1.
  - Row increments first (column-major write order).
- The section field comes from the head word. A head value ≥ NUM_SECTIONS is written as-is, unchecked.
- pix_out = TEST_MODE ? low NUM_PIX bits of pix_out_addr : head pixels.
- pix_out and pix_out_addr are forced to 0 whenever pix_out_wren is low.
- Resync: if the head word has sof=1 and (row,col)≠(0,0):
  - the word is written at wr_addr 0 of the current buffer;
  - counters become row=1, col=0;
  - sync_err_cnt increments, saturating at 255.
- Section end: the last word (row=THIRD_ROWS-1, col=WR_COLS-1) resets the counters to 0.
- Image end: a section end whose section index is NUM_SECTIONS-1. Let nxt = (cur_buf+1) mod NUM_BUFS.
  - If bm_busy_mask[nxt]==0: cur_buf<=nxt, image_number+1, frame_done=1, done_buf<=old cur_buf.
  - Else: go to ST_STALL.
- ST_STALL: no reads; the FIFO still accepts input. When bm_busy_mask[nxt]==0, perform the same advance and return to ST_RUN.
- Reset mid-operation: FIFO flushed; all counters, flags and state cleared.

## Timing
- Reset values:
  - pix_out_wren, pix_out, pix_out_addr = 0
  - cur_buf, done_buf, image_number, sync_err_cnt = 0
  - frame_done, fifo_overflow, fifo_almost_full = 0
  - state = ST_RUN
- Latency: a word written on edge N gives pix_out_wren=1 in the cycle after edge N (1 cycle), provided the FIFO was empty and state is ST_RUN.
- Throughput is 1 word/clk in ST_RUN.
- frame_done, image_number and cur_buf update on the edge that consumes the last word when not stalled. Otherwise they update on the edge where ST_STALL sees the buffer free. That edge also moves the FSM back to ST_RUN, so the first write to the new buffer comes on the next edge, a 1-cycle bubble.
- bm_busy_mask is sampled combinationally, with no extra registering.
- fifo_almost_full is registered from used words and lags by 1 cycle.

## Test plan
Test configuration: THIRD_COLS=32, THIRD_ROWS=4, NUM_PIX=16, NUM_SECTIONS=3, NUM_BUFS=3 (8 words per section).
- Single section 0, contiguous 8 words -> wren on 8 consecutive cycles, addr low bits 0,2,4,6,1,3,5,7, section field 0, buf 0.
- Three sections, bm_busy_mask=0 -> one frame_done pulse on the 24th write, done_buf=0, cur_buf=1, image_number=1. Three more images -> cur_buf cycles 2, 0, 1.
- Busy stall: bm_busy_mask=3'b010 at the end of image 0 -> state ST_STALL, no wren. Clear the mask after 20 cycles -> frame_done that cycle, first write to buf 1 addr 0 next cycle, no words lost.
- SOF resync: sof on word 3 of a section -> that word at addr 0, the next at addr 2, sync_err_cnt=1.
- Overflow: FIFO_DEPTH=16, stall held, 17 words pushed -> fifo_almost_full after used>AFULL_LEVEL, fifo_overflow=1, exactly 16 words written after release.
- TEST_MODE=1 -> pix_out equals the low 16 bits of pix_out_addr on every write. Reset asserted mid-image -> all outputs 0 the next cycle, then a restart at addr 0, buf 0.
